// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encodings for the GCD engine
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    FINISH  = 2'b10
  } state_t;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - operand registers, subtractor and magnitude comparator
module gcd_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_val,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Operand registers: load a new pair, or replace the larger operand by the difference.
  // Each subtraction is additionally gated by the comparator so the minuend is always larger.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (sub_a && gt) begin
      a_q <= a_q - b_q;
    end else if (sub_b && lt) begin
      b_q <= b_q - a_q;
    end
  end

  assign lt    = (a_q <  b_q);
  assign gt    = (a_q >  b_q);
  assign eq    = (a_q == b_q);
  assign a_val = a_q;

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtraction-based GCD controller with result registers
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_count,
  output logic             zero_op
);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             sub_a;
  logic             sub_b;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] a_val;
  logic             zero_req;

  assign zero_req = (a_in == '0) || (b_in == '0);

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .sub_a (sub_a),
    .sub_b (sub_b),
    .a_in  (a_in),
    .b_in  (b_in),
    .a_val (a_val),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  // State register; reset wins over everything, aborting any computation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control strobes; unused encodings fall back to IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sub_a      = 1'b0;
    sub_b      = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (zero_req) begin
            state_next = FINISH;
          end else begin
            load       = 1'b1;
            state_next = COMPARE;
          end
        end
      end
      COMPARE: begin
        busy = 1'b1;
        if (eq) begin
          state_next = FINISH;
        end else if (lt) begin
          sub_b = 1'b1;
        end else if (gt) begin
          sub_a = 1'b1;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result registers: only touched on an accepted start or while comparing, so they hold after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcd_out    <= '0;
      iter_count <= '0;
      zero_op    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_count <= '0;
            if (zero_req) begin
              gcd_out <= a_in | b_in;
              zero_op <= 1'b1;
            end else begin
              zero_op <= 1'b0;
            end
          end
        end
        COMPARE: begin
          if (eq) begin
            gcd_out <= a_val;
          end else if (lt || gt) begin
            iter_count <= iter_count + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - randomized self-checking bench for gcd_engine
module tb_gcd_engine;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd_out;
  logic [W-1:0] iter_count;
  logic         zero_op;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .gcd_out    (gcd_out),
    .iter_count (iter_count),
    .zero_op    (zero_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Euclid by division. Subtractive steps = sum of quotients - 1.
  function automatic void ref_gcd(input int a, input int b, output int g, output int it);
    int x, y, r;
    if (a == 0 || b == 0) begin
      g  = a | b;
      it = 0;
    end else begin
      x  = (a > b) ? a : b;
      y  = (a > b) ? b : a;
      it = -1;
      while (y != 0) begin
        it = it + x / y;
        r  = x % y;
        x  = y;
        y  = r;
      end
      g = x;
    end
  endfunction

  // Drives one request and measures cycles from the accepting edge to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cyc, output bit timeout);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    timeout  = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cyc++;
      if (lat >= 1000) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({ready, busy, done, zero_op} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=1000", {ready, busy, done, zero_op});
    end
    n_tests++;
    if ({gcd_out, iter_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs gcd=%0d iter=%0d exp=0/0", gcd_out, iter_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    bit to;
    run_op(8'd12, 8'd8, lat, bc, to);
    n_tests++;
    if (to || lat != 4 || bc != 3) begin
      n_fail++;
      $display("FAIL basic_timing lat=%0d busy=%0d to=%0d exp lat=4 busy=3", lat, bc, to);
    end
    n_tests++;
    if (gcd_out !== 8'd4 || iter_count !== 8'd2 || zero_op !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result gcd=%0d iter=%0d z=%0d exp 4/2/0", gcd_out, iter_count, zero_op);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (ready !== 1'b1 || gcd_out !== 8'd4 || iter_count !== 8'd2 || zero_op !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold rdy=%0d gcd=%0d iter=%0d exp 1/4/2", ready, gcd_out, iter_count);
    end
  endtask

  task automatic test_equal();
    int lat, bc;
    bit to;
    run_op(8'd7, 8'd7, lat, bc, to);
    n_tests++;
    if (to || lat != 2 || gcd_out !== 8'd7 || iter_count !== 8'd0) begin
      n_fail++;
      $display("FAIL equal lat=%0d gcd=%0d iter=%0d exp 2/7/0", lat, gcd_out, iter_count);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    bit to;
    run_op(8'd0, 8'd9, lat, bc, to);
    n_tests++;
    if (to || lat != 1 || gcd_out !== 8'd9 || zero_op !== 1'b1 || iter_count !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_b lat=%0d gcd=%0d z=%0d iter=%0d exp 1/9/1/0", lat, gcd_out, zero_op, iter_count);
    end
    run_op(8'd0, 8'd0, lat, bc, to);
    n_tests++;
    if (to || lat != 1 || gcd_out !== 8'd0 || zero_op !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_both lat=%0d gcd=%0d z=%0d exp 1/0/1", lat, gcd_out, zero_op);
    end
  endtask

  task automatic test_worst_case();
    int lat, bc;
    bit to;
    run_op(8'd1, 8'd255, lat, bc, to);
    n_tests++;
    if (to || lat != 256 || gcd_out !== 8'd1 || iter_count !== 8'd254) begin
      n_fail++;
      $display("FAIL worst lat=%0d gcd=%0d iter=%0d exp 256/1/254", lat, gcd_out, iter_count);
    end
  endtask

  task automatic test_held_start();
    int cyc;
    @(negedge clk);
    a_in  = 8'd35;
    b_in  = 8'd21;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      if (cyc == 2) begin
        a_in = 8'd6;
        b_in = 8'd4;
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != 5 || gcd_out !== 8'd7 || iter_count !== 8'd3) begin
      n_fail++;
      $display("FAIL held_first lat=%0d gcd=%0d iter=%0d exp 5/7/3", cyc, gcd_out, iter_count);
    end
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL held_idle ready=%0d exp 1", ready);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_reaccept busy=%0d exp 1", busy);
    end
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc >= 1000 || gcd_out !== 8'd2 || iter_count !== 8'd2) begin
      n_fail++;
      $display("FAIL held_second gcd=%0d iter=%0d cyc=%0d exp 2/2", gcd_out, iter_count, cyc);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    bit to;
    bit seen_done;
    @(negedge clk);
    a_in  = 8'd100;
    b_in  = 8'd75;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy busy=%0d exp 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({ready, busy, done, zero_op} !== 4'b1000 || gcd_out !== 8'd0 || iter_count !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_state flags=%b gcd=%0d iter=%0d exp 1000/0/0",
               {ready, busy, done, zero_op}, gcd_out, iter_count);
    end
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_no_done done_seen=1 exp 0");
    end
    run_op(8'd100, 8'd75, lat, bc, to);
    n_tests++;
    if (to || gcd_out !== 8'd25 || iter_count !== 8'd3) begin
      n_fail++;
      $display("FAIL abort_rerun gcd=%0d iter=%0d exp 25/3", gcd_out, iter_count);
    end
  endtask

  task automatic test_random();
    int lat, bc, g, it, a, b;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(1, 255);
      b = $urandom_range(1, 255);
      if ($urandom_range(0, 9) == 0) a = 0;
      if ($urandom_range(0, 9) == 0) b = 0;
      ref_gcd(a, b, g, it);
      run_op(a[W-1:0], b[W-1:0], lat, bc, to);
      n_tests++;
      if (to || lat != ((a == 0 || b == 0) ? 1 : it + 2) || int'(gcd_out) != g ||
          int'(iter_count) != it || zero_op !== ((a == 0 || b == 0) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL random(%0d,%0d) gcd=%0d iter=%0d lat=%0d z=%0d exp gcd=%0d iter=%0d",
                 a, b, gcd_out, iter_count, lat, zero_op, g, it);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_zero();
    test_worst_case();
    test_held_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to begin a computation; sampled only while ready=1.
REQ-005 SHALL have port a_in, input, WIDTH, first operand (unsigned), sampled with start.
REQ-006 SHALL have port b_in, input, WIDTH, second operand (unsigned), sampled with start.
REQ-007 SHALL have port ready, output, 1, engine idle and able to accept start.
REQ-008 SHALL have port busy, output, 1, computation in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when gcd_out becomes valid.
REQ-010 SHALL have port gcd_out, output, WIDTH, result register.
REQ-011 SHALL have port iter_count, output, WIDTH, number of subtraction steps used by the last computation.
REQ-012 SHALL have port zero_op, output, 1, last accepted request had at least one zero operand.

Function
REQ-013 SHALL implement FSM states IDLE, COMPARE, FINISH; ready=1 only in IDLE; busy=1 only in COMPARE; done=1 only in FINISH.
REQ-014 SHALL, in IDLE with start=1 and both operands non-zero, load A<=a_in, B<=b_in, clear iter_count and zero_op, and go to COMPARE on the same edge.
REQ-015 SHALL, in IDLE with start=1 and a_in==0 or b_in==0, set gcd_out<=a_in|b_in, zero_op<=1, iter_count<=0, and go directly to FINISH (gcd(0,0)=0).
REQ-016 SHALL, each COMPARE cycle: if A==B then gcd_out<=A and go to FINISH; else if A<B then B<=B-A; else A<=A-B; in the last two cases iter_count increments by 1.
REQ-017 SHALL use the datapath status signals lt, gt, eq (mutually exclusive, combinational from A and B) to drive the COMPARE decision.
REQ-018 SHALL leave FINISH unconditionally for IDLE after exactly one cycle.
REQ-019 SHALL give latency from the start-accepting edge to done high of (iterations + 2) cycles for non-zero operands and 1 cycle for zero operands.
REQ-020 SHALL ignore start while not in IDLE, including start held high through FINISH; a held start is re-accepted on the first IDLE cycle.
REQ-021 SHALL hold gcd_out, iter_count and zero_op stable from FINISH until the next accepted start.
REQ-022 SHALL never overflow iter_count; worst case gcd(1, 2^WIDTH-1) needs 2^WIDTH-2 steps, which fits in WIDTH bits.
REQ-023 SHALL never underflow: a subtraction only occurs when the minuend is strictly greater.
REQ-024 SHALL map any unused FSM encoding to IDLE on the next edge.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, enter IDLE and clear A, B, gcd_out, iter_count, zero_op and done to 0; ready=1 and busy=0 on the following cycle.
REQ-026 SHALL let rst take priority over start and abort any computation in progress without producing done.

Structure
REQ-027 SHALL place the FSM state encodings (IDLE=2'b00, COMPARE=2'b01, FINISH=2'b10) in shared package gcd_pkg.
REQ-028 SHALL split the design into the top-level controller and one sub-module, gcd_datapath, which holds registers A/B, the subtractor, and the lt/gt/eq comparator.

Verification
REQ-029 SHALL cover a_in=12, b_in=8 with start pulsed once -> COMPARE for 3 cycles, done on the 4th cycle after acceptance, gcd_out=4, iter_count=2, zero_op=0.
REQ-030 SHALL cover a_in=7, b_in=7 -> done 2 cycles after acceptance, gcd_out=7, iter_count=0.
REQ-031 SHALL cover a_in=0, b_in=9 -> done 1 cycle after acceptance, gcd_out=9, zero_op=1; and a_in=0, b_in=0 -> gcd_out=0, zero_op=1.
REQ-032 SHALL cover WIDTH=8 with a_in=1, b_in=255 -> iter_count=254, gcd_out=1, no wrap of either counter or operand.
REQ-033 SHALL cover start held high continuously with a_in=35, b_in=21, then a change of operands to 6, 4 mid-computation -> first result 7 is unaffected by the change; a second computation starts in the cycle after FINISH and gives result 2.
REQ-034 SHALL cover rst asserted during COMPARE of 100, 75 -> no done pulse, all outputs 0, ready=1 on the next cycle; a following start with 100, 75 gives gcd_out=25.
